// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
//
// Memory controller and arbiter for the single byte-wide RAM/IO port.
// Instruction fetch and the load/store buffer (LSB) compete for the port.
// One request is served at a time. Each request is sequenced into 1..4
// single-byte RAM cycles. Read bytes are assembled little-endian.
//
// Build option:
//   MEMCTRL_RR_EN  defined   -> round-robin between LSB and fetch on conflict
//                  undefined -> fixed priority, LSB always wins a conflict
//
// Ports:
//   clk_in          in   1   clock, rising edge
//   rst_n_in        in   1   asynchronous active-low reset
//   rdy_in          in   1   global ready; low freezes all state, masks mem_wr
//   clear           in   1   misprediction flush (aborts LOAD/FETCH)
//   io_buffer_full  in   1   UART TX buffer full (blocks IO stores)
//   mem_din         in   8   RAM read byte
//   mem_dout        out  8   RAM write byte
//   mem_a           out  32  RAM byte address
//   mem_wr          out  1   write strobe, 1 = write
//   go_work         in   1   LSB request (level)
//   l_or_s          in   1   0 = load, 1 = store
//   width           in   3   byte count 1, 2 or 4
//   address         in   32  LSB byte address
//   value_store     in   32  store data
//   received        out  1   pulse: LSB request accepted
//   has_result      out  1   pulse: value_load valid
//   value_load      out  32  load data, zero-extended
//   if_req          in   1   fetch request (level)
//   if_addr         in   32  fetch address (word aligned)
//   if_ready        out  1   pulse: if_data valid
//   if_data         out  32  fetched instruction
//   dbg_state       out  2   FSM state: 0 IDLE, 1 LOAD, 2 STORE, 3 FETCH
//
// Handshake: go_work and if_req are level requests that the requester holds
// until accepted. The LSB sees acceptance as a one-cycle received pulse;
// fetch sees completion as a one-cycle if_ready pulse. Results are valid
// only in the cycle their pulse is high.
// ---------------------------------------------------------------------------
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        go_work,
    input  logic        l_or_s,
    input  logic [2:0]  width,
    input  logic [31:0] address,
    input  logic [31:0] value_store,
    output logic        received,
    output logic        has_result,
    output logic [31:0] value_load,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_FETCH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;     // index of the final byte, i.e. w-1
    logic [31:0] base_q, base_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        received_q, received_d;
    logic        has_result_q, has_result_d;
    logic [31:0] value_load_q, value_load_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] if_data_q, if_data_d;

`ifdef MEMCTRL_RR_EN
    // 1 = fetch wins the next conflict, 0 = LSB wins it.
    logic        rr_fetch_q, rr_fetch_d;
`endif

    logic        io_store;
    logic        lsb_ok;
    logic        pick_fetch;
    logic        pick_lsb;
    logic        can_grant;
    logic [1:0]  cnt_nxt;
    logic [31:0] data_cap;

    // Width 1 -> last byte 0, width 2 -> last byte 1, anything else is a
    // full word. Mapping illegal widths to 4 keeps the FSM from stalling.
    function automatic logic [1:0] last_of(input logic [2:0] w);
        logic [1:0] r;
        case (w)
            3'd1:    r = 2'd0;
            3'd2:    r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] d,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = d;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // An IO store must not be issued while the UART buffer is full; the LSB
    // request stays pending and fetch is free to take the port meanwhile.
    assign io_store = l_or_s && (address[17:16] == 2'b11);
    assign lsb_ok   = go_work && !(io_store && io_buffer_full);

`ifdef MEMCTRL_RR_EN
    assign pick_fetch = if_req && (!lsb_ok || rr_fetch_q);
`else
    assign pick_fetch = if_req && !lsb_ok;
`endif
    assign pick_lsb   = lsb_ok && !pick_fetch;

    // No grant on the edge closing a received cycle, nor on a flush edge.
    assign can_grant  = !clear && !received_q;

    assign cnt_nxt  = cnt_q + 2'd1;
    assign data_cap = put_byte(data_q, cnt_q, mem_din);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        base_d       = base_q;
        data_d       = data_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        received_d   = 1'b0;
        has_result_d = 1'b0;
        value_load_d = value_load_q;
        if_ready_d   = 1'b0;
        if_data_d    = if_data_q;
`ifdef MEMCTRL_RR_EN
        rr_fetch_d   = rr_fetch_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (can_grant && pick_lsb) begin
                    received_d = 1'b1;
                    base_d     = address;
                    mem_a_d    = address;
                    cnt_d      = 2'd0;
                    last_d     = last_of(width);
`ifdef MEMCTRL_RR_EN
                    rr_fetch_d = 1'b1;
`endif
                    if (l_or_s) begin
                        // Byte 0 goes out now; the remaining bytes are kept
                        // right-aligned and shifted out one per cycle.
                        state_d    = ST_STORE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = value_store[7:0];
                        data_d     = {8'h00, value_store[31:8]};
                    end else begin
                        // Clearing the register gives zero extension for
                        // narrow loads.
                        state_d  = ST_LOAD;
                        mem_wr_d = 1'b0;
                        data_d   = 32'h0;
                    end
                end else if (can_grant && pick_fetch) begin
                    state_d  = ST_FETCH;
                    base_d   = if_addr;
                    mem_a_d  = if_addr;
                    cnt_d    = 2'd0;
                    last_d   = 2'd3;
                    mem_wr_d = 1'b0;
                    data_d   = 32'h0;
`ifdef MEMCTRL_RR_EN
                    rr_fetch_d = 1'b0;
`endif
                end
            end

            ST_LOAD, ST_FETCH: begin
                if (clear) begin
                    // Flushed read: drop it silently, no result pulse.
                    state_d  = ST_IDLE;
                    mem_wr_d = 1'b0;
                    mem_a_d  = 32'h0;
                end else begin
                    data_d = data_cap;
                    if (cnt_q == last_q) begin
                        state_d = ST_IDLE;
                        mem_a_d = 32'h0;
                        if (state_q == ST_LOAD) begin
                            has_result_d = 1'b1;
                            value_load_d = data_cap;
                        end else begin
                            if_ready_d = 1'b1;
                            if_data_d  = data_cap;
                        end
                    end else begin
                        cnt_d   = cnt_nxt;
                        mem_a_d = base_q + {30'h0, cnt_nxt};
                    end
                end
            end

            ST_STORE: begin
                // Stores reaching here are committed, so clear is ignored.
                if (cnt_q == last_q) begin
                    state_d  = ST_IDLE;
                    mem_wr_d = 1'b0;
                end else begin
                    cnt_d      = cnt_nxt;
                    mem_a_d    = base_q + {30'h0, cnt_nxt};
                    mem_dout_d = data_q[7:0];
                    data_d     = {8'h00, data_q[31:8]};
                end
            end

            default: begin
                state_d  = ST_IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; rdy_in low holds everything in place.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            base_q       <= 32'h0;
            data_q       <= 32'h0;
            mem_a_q      <= 32'h0;
            mem_dout_q   <= 8'h00;
            mem_wr_q     <= 1'b0;
            received_q   <= 1'b0;
            has_result_q <= 1'b0;
            value_load_q <= 32'h0;
            if_ready_q   <= 1'b0;
            if_data_q    <= 32'h0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            base_q       <= base_d;
            data_q       <= data_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            received_q   <= received_d;
            has_result_q <= has_result_d;
            value_load_q <= value_load_d;
            if_ready_q   <= if_ready_d;
            if_data_q    <= if_data_d;
        end
    end

`ifdef MEMCTRL_RR_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_fetch_q <= 1'b0;
        end else if (rdy_in) begin
            rr_fetch_q <= rr_fetch_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The write strobe is masked combinationally so a frozen pipeline
    // never repeats a write into the RAM.
    assign mem_wr     = mem_wr_q & rdy_in;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign received   = received_q;
    assign has_result = has_result_q;
    assign value_load = value_load_q;
    assign if_ready   = if_ready_q;
    assign if_data    = if_data_q;
    assign dbg_state  = state_q;

endmodule
